bool_xor_sequencer: RTL and testbench

Operand sequencer wrapped around the combinational `p_xor` stage of the boolean unit. It accepts two operands one after the other over a single valid/ready input bus and drives them as `in_bus1`/`in_bus2` of `p_xor`. It then captures `p_xor`'s `out_bus` into a result register and presents it downstream with a valid/ready handshake. It turns the stateless XOR into a transaction-level stage the CPU datapath can stall against.

---
 rtl/bool_xor_sequencer_if.sv | 23 ++
 rtl/bool_xor_sequencer.sv | 59 +++++
 tb/tb_bool_xor_sequencer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/bool_xor_sequencer_if.sv
// bool_xor_sequencer_if: operand/result handshake bundle between the sequencer and its environment
interface bool_xor_sequencer_if #(parameter int BUS_WIDTH = 4);
  logic [BUS_WIDTH-1:0] in_bus;
  logic                 in_valid;
  logic                 in_ready;
  logic [BUS_WIDTH-1:0] xor_in_bus1;
  logic [BUS_WIDTH-1:0] xor_in_bus2;
  logic [BUS_WIDTH-1:0] xor_out_bus;
  logic [BUS_WIDTH-1:0] out_bus;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_zero;
  logic [7:0]           result_count;
  logic                 busy;
  modport master (
    output in_bus, in_valid, xor_out_bus, out_ready,
    input  in_ready, xor_in_bus1, xor_in_bus2, out_bus, out_valid, out_zero, result_count, busy
  );
  modport slave (
    input  in_bus, in_valid, xor_out_bus, out_ready,
    output in_ready, xor_in_bus1, xor_in_bus2, out_bus, out_valid, out_zero, result_count, busy
  );
endinterface

// File: rtl/bool_xor_sequencer.sv
// bool_xor_sequencer: two-beat operand loader around p_xor with a registered, backpressured result
module bool_xor_sequencer #(
  parameter int BUS_WIDTH = 4
) (
  input logic                    clk,
  input logic                    reset_n,
  input logic                    flush,
  bool_xor_sequencer_if.slave    s
);
  typedef enum logic [1:0] {LOAD_A, LOAD_B, EVAL, HOLD} state_t;
  state_t               state_q;
  logic [BUS_WIDTH-1:0] op1_q, op2_q, out_bus_q;
  logic                 out_valid_q, out_zero_q;
  logic [7:0]           result_count_q;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= LOAD_A;
      op1_q          <= '0;
      op2_q          <= '0;
      out_bus_q      <= '0;
      out_valid_q    <= 1'b0;
      out_zero_q     <= 1'b0;
      result_count_q <= 8'd0;
    end else if (flush) begin
      state_q     <= LOAD_A;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        LOAD_A: if (s.in_valid) begin
          op1_q   <= s.in_bus;
          state_q <= LOAD_B;
        end
        LOAD_B: if (s.in_valid) begin
          op2_q   <= s.in_bus;
          state_q <= EVAL;
        end
        EVAL: begin
          out_bus_q   <= s.xor_out_bus;
          out_zero_q  <= ~|s.xor_out_bus;
          out_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: if (s.out_ready) begin
          out_valid_q    <= 1'b0;
          result_count_q <= result_count_q + 8'd1;
          state_q        <= LOAD_A;
        end
      endcase
    end
  end
  assign s.in_ready     = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign s.busy         = state_q != LOAD_A;
  assign s.xor_in_bus1  = op1_q;
  assign s.xor_in_bus2  = op2_q;
  assign s.out_bus      = out_bus_q;
  assign s.out_valid    = out_valid_q;
  assign s.out_zero     = out_zero_q;
  assign s.result_count = result_count_q;
endmodule

// File: tb/tb_bool_xor_sequencer.sv
// tb_bool_xor_sequencer: directed and random transactions against a transaction-level model
module tb_bool_xor_sequencer;
  logic clk = 1'b0;
  logic reset_n, flush;
  int total = 0, bad = 0;
  bool_xor_sequencer_if #(.BUS_WIDTH(4)) ifc ();
  bool_xor_sequencer #(.BUS_WIDTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .s(ifc.slave)
  );
  always #5 clk = ~clk;
  assign ifc.xor_out_bus = ifc.xor_in_bus1 ^ ifc.xor_in_bus2;
  int         beats = 0;
  logic [3:0] m_a, m_b, m_out;
  logic       m_valid, m_zero;
  logic [7:0] m_cnt;
  bit         chk_en = 0;
  // beats: operands taken so far in this transaction; 2 = computing, 3 = presenting
  always @(posedge clk) begin
    if (!reset_n) begin
      beats <= 0; m_a <= 0; m_b <= 0; m_out <= 0; m_valid <= 0; m_zero <= 0; m_cnt <= 0; chk_en <= 1;
    end else if (flush) begin
      beats <= 0; m_valid <= 0;
    end else if (beats < 2) begin
      if (ifc.in_valid) begin
        if (beats == 0) m_a <= ifc.in_bus; else m_b <= ifc.in_bus;
        beats <= beats + 1;
      end
    end else if (beats == 2) begin
      m_out <= m_a ^ m_b; m_zero <= ((m_a ^ m_b) == 4'd0); m_valid <= 1; beats <= 3;
    end else if (ifc.out_ready) begin
      m_valid <= 0; m_cnt <= m_cnt + 8'd1; beats <= 0;
    end
  end
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    cmp("m_in_ready", ifc.in_ready, beats < 2);
    cmp("m_busy", ifc.busy, beats != 0);
    cmp("m_bus1", ifc.xor_in_bus1, m_a);
    cmp("m_bus2", ifc.xor_in_bus2, m_b);
    cmp("m_out_bus", ifc.out_bus, m_out);
    cmp("m_out_valid", ifc.out_valid, m_valid);
    cmp("m_out_zero", ifc.out_zero, m_zero);
    cmp("m_count", ifc.result_count, m_cnt);
  end
  task automatic cyc();
    @(posedge clk); #1;
  endtask
  task automatic send(input logic [3:0] v);
    int n = 0;
    ifc.in_valid = 1; ifc.in_bus = v;
    while (!ifc.in_ready && n < 20) begin cyc(); n++; end
    if (n == 20) cmp("send_timeout", 0, 1);
    cyc();
    ifc.in_valid = 0;
  endtask
  initial begin
    reset_n = 0; flush = 0;
    ifc.in_valid = 0; ifc.in_bus = 0; ifc.out_ready = 0;
    cyc(); cyc();
    cmp("reset_out_valid", ifc.out_valid, 0);
    cmp("reset_count", ifc.result_count, 0);
    cmp("reset_in_ready", ifc.in_ready, 1);
    reset_n = 1;
    ifc.out_ready = 1;
    send(4'b1101); send(4'b1011);
    cmp("basic_not_yet", ifc.out_valid, 0);
    cyc();
    cmp("basic_valid", ifc.out_valid, 1);
    cmp("basic_bus", ifc.out_bus, 4'b0110);
    cmp("basic_zero", ifc.out_zero, 0);
    cyc();
    cmp("basic_valid_drop", ifc.out_valid, 0);
    cmp("basic_count", ifc.result_count, 1);
    cmp("basic_busy", ifc.busy, 0);
    send(4'b0101); send(4'b0101); cyc();
    cmp("zero_bus", ifc.out_bus, 0);
    cmp("zero_flag", ifc.out_zero, 1);
    cyc();
    ifc.out_ready = 0;
    send(4'b1010); send(4'b0101); cyc();
    ifc.in_valid = 1; ifc.in_bus = 4'b0011;
    repeat (5) begin
      cyc();
      cmp("bp_bus", ifc.out_bus, 4'b1111);
      cmp("bp_valid", ifc.out_valid, 1);
      cmp("bp_in_ready", ifc.in_ready, 0);
      cmp("bp_op1", ifc.xor_in_bus1, 4'b1010);
      cmp("bp_op2", ifc.xor_in_bus2, 4'b0101);
    end
    cmp("bp_count_held", ifc.result_count, 2);
    ifc.in_valid = 0; ifc.out_ready = 1; cyc();
    cmp("bp_count", ifc.result_count, 3);
    cyc();
    cmp("bp_count_once", ifc.result_count, 3);
    send(4'b1100);
    repeat (3) begin
      cyc();
      cmp("gap_in_ready", ifc.in_ready, 1);
      cmp("gap_busy", ifc.busy, 1);
      cmp("gap_op1", ifc.xor_in_bus1, 4'b1100);
    end
    send(4'b0110); cyc();
    cmp("gap_bus", ifc.out_bus, 4'b1010);
    cyc();
    send(4'b1111);
    flush = 1; ifc.in_valid = 1; ifc.in_bus = 4'b0001; cyc();
    flush = 0; ifc.in_valid = 0;
    cmp("flb_in_ready", ifc.in_ready, 1);
    cmp("flb_busy", ifc.busy, 0);
    cmp("flb_op2_kept", ifc.xor_in_bus2, 4'b0110);
    send(4'b0011); send(4'b0101); cyc();
    cmp("flb_bus", ifc.out_bus, 4'b0110);
    cyc();
    cmp("flb_count", ifc.result_count, 5);
    ifc.out_ready = 0;
    send(4'b1000); send(4'b0001); cyc();
    cmp("flh_valid_pre", ifc.out_valid, 1);
    flush = 1; ifc.out_ready = 1; cyc();
    flush = 0; ifc.out_ready = 0;
    cmp("flh_valid", ifc.out_valid, 0);
    cmp("flh_count", ifc.result_count, 5);
    cmp("flh_bus_kept", ifc.out_bus, 4'b1001);
    send(4'b0111); send(4'b0010);
    reset_n = 0; cyc(); reset_n = 1;
    cmp("rst_bus", ifc.out_bus, 0);
    cmp("rst_op1", ifc.xor_in_bus1, 0);
    cmp("rst_op2", ifc.xor_in_bus2, 0);
    cmp("rst_count", ifc.result_count, 0);
    ifc.out_ready = 1;
    repeat (3) begin cyc(); cmp("rst_no_valid", ifc.out_valid, 0); end
    repeat (400) begin
      ifc.in_valid = 1'($urandom_range(1)); ifc.in_bus = 4'($urandom);
      ifc.out_ready = 1'($urandom_range(1));
      flush = ($urandom_range(15) == 0); reset_n = ($urandom_range(63) != 0);
      cyc();
    end
    flush = 0; ifc.in_valid = 0; ifc.out_ready = 1;
    reset_n = 0; cyc(); reset_n = 1;
    for (int i = 0; i < 256; i++) begin
      send(4'($urandom)); send(4'($urandom)); cyc(); cyc();
      if (i == 254) cmp("wrap_255", ifc.result_count, 255);
    end
    cmp("wrap_0", ifc.result_count, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
